radix2_div_unit: RTL
====================

Name: radix2_div_unit

Overview:
- Iterative restoring radix-2 integer divider. It is the responder side of the EXE-stage divide request interface: level request, operands and signedness in; quotient, remainder and a completion flag out.
- Serves DIV/DIVU. EXE holds the request until completion and then clears the unit with a resetn pulse whenever the pipeline flows.
- One quotient bit per cycle; results are registered and held until the request drops.

Parameters:
- WIDTH, 32, operand/quotient/remainder width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- div  input  1  divide request, level-sensitive; held high by the requester until complete.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at accept.
- a  input  WIDTH  dividend; sampled at accept.
- b  input  WIDTH  divisor; sampled at accept.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- complete  output  1  result valid; high in DONE.
- busy  output  1  high in BUSY.

Behaviour:
- Reset: when resetn=0 at a clock edge, the state becomes IDLE and q=0, r=0, complete=0, busy=0; counter and working registers are cleared.
- Reset has priority over all other events, including mid-BUSY and DONE; any in-flight operation is discarded with no complete.

States:
- IDLE: if div=1, accept at this edge and go to BUSY. The accept latches sign_q=is_signed&(a[MSB]^b[MSB]), sign_r=is_signed&a[MSB], |a| and |b| (magnitudes only when is_signed), a raw copy of a, b==0 flag, partial remainder=0, count=0.
- BUSY: each cycle, shift {rem,dividend} left by 1, trial-subtract |b|, keep the difference if non-negative and set the quotient bit; count++.
  - After the WIDTH-th iteration (count==WIDTH-1 at the edge), go to DONE and register the final q/r.
  - If div=0 in any BUSY cycle, abort to IDLE at that edge; q/r unchanged, complete stays 0.
- DONE: complete=1; q/r held stable.
  - Stay while div=1; no restart while div stays high.
  - When div=0, go to IDLE; complete drops at that edge; q/r keep their values until the next DONE entry.

Timing:
- Request sampled high at edge E0 (accept). Iterations occur at edges E1..EWIDTH. complete=1 from edge EWIDTH, i.e. the 32nd cycle after accept for WIDTH=32, q/r valid in the same cycle.
- busy=1 from E0 up to EWIDTH.
- A new request needs div low for at least 1 cycle, or a resetn pulse, after DONE.

Sign fix (applied when registering results):
- q = sign_q ? -q_mag : q_mag.
- r = sign_r ? -r_mag : r_mag.
- Quotient truncates toward zero; the remainder takes the dividend's sign.

Special cases:
- b==0 (latched): q=all ones, r=raw a, regardless of is_signed; same latency.
- Signed overflow, a=0x80000000 and b=0xFFFFFFFF: q=0x80000000, r=0 (falls out of the magnitude path); no exception flag.

Stability:
- Operand and is_signed changes after accept are ignored.
- All outputs come directly from registers; no combinational input-to-output path.

Test Plan:
- Unsigned 100/7, div held high: accept at E0 -> complete rises at E32; q=14, r=2; busy high E0..E31; outputs stable while div stays high; complete drops at the edge after div falls.
- Signed 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Signed 7 / 0xFFFFFFFE (-2) -> q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF.
- Corner cases: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. Divide by zero, a=0x12345678 (signed and unsigned) -> q=0xFFFFFFFF, r=0x12345678, complete at E32.
- Abort: drop div 10 cycles after accept -> state IDLE at that edge, complete never asserts. Re-request 1 cycle later with 9/3 -> q=3, r=0, complete 32 cycles after the new accept.
- Reset mid-op: pulse resetn low for 1 cycle during BUSY, and separately during DONE -> q=r=0, complete=busy=0 next cycle. With div still high after reset, a fresh accept occurs and the result is correct.
- Operand churn: randomise a/b/is_signed every cycle after accept -> result matches the operands latched at E0.

Source files
------------

// File: rtl/radix2_div_unit.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, signed or unsigned.
// Results are registered on the final iteration and held until the request drops.
//
// state  | meaning
// IDLE   | waiting for div; accepts operands on the first edge div is high
// BUSY   | shift/trial-subtract iterations, one per cycle
// DONE   | complete=1, q/r held until div drops
module radix2_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             complete,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_raw;
    logic             b_zero;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             iterate;
    logic             last_iter;
    logic [WIDTH:0]   rem_shift;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        accept    = (state == S_IDLE) && div;
        iterate   = (state == S_BUSY) && div;
        last_iter = iterate && (count == LAST);

        // Partial remainder is below |b|, so after the shift it needs one extra bit;
        // when the trial succeeds the difference is below |b| again and fits WIDTH bits.
        rem_shift = {rem, dvd[WIDTH-1]};
        trial_ok  = (rem_shift >= {1'b0, b_mag});
        rem_nxt   = trial_ok ? (rem_shift[WIDTH-1:0] - b_mag) : rem_shift[WIDTH-1:0];
        dvd_nxt   = {dvd[WIDTH-2:0], trial_ok};

        a_mag_in  = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag_in  = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

        if (b_zero) begin
            q_fix = '1;
            r_fix = a_raw;
        end else begin
            q_fix = sign_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
            r_fix = sign_r ? (~rem_nxt + 1'b1) : rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (div) state_nxt = S_BUSY;
            S_BUSY: begin
                if (!div)           state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  if (!div) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_BUSY);
        complete = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count  <= '0;
            rem    <= '0;
            dvd    <= '0;
            b_mag  <= '0;
            a_raw  <= '0;
            b_zero <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            q      <= '0;
            r      <= '0;
        end else if (accept) begin
            count  <= '0;
            rem    <= '0;
            dvd    <= a_mag_in;
            b_mag  <= b_mag_in;
            a_raw  <= a;
            b_zero <= (b == '0);
            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= is_signed & a[WIDTH-1];
        end else if (iterate) begin
            count <= count + CW'(1);
            rem   <= rem_nxt;
            dvd   <= dvd_nxt;
            if (last_iter) begin
                q <= q_fix;
                r <= r_fix;
            end
        end
    end

endmodule
